multicycle_sequencer: RTL and testbench

Parametrised control sequencer for the multicycle RV32I datapath. It steps each instruction through Fetch, Decode, Execute, Memory and Writeback, and waits on a ready handshake from memory so that multi-cycle memories can be used. It adds three things the fixed-latency controller lacks: halt/resume at instruction boundaries, a memory-timeout fault, and cycle/retired-instruction counters. It sits between the instruction decoder (class input) and the PC, IR, register file and memory enables.

---
 rtl/multicycle_sequencer.sv | 177 +++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Control sequencer for the multicycle RV32I datapath.
// Walks each instruction through fetch/decode/execute/memory/writeback,
// waits on a memory ready handshake, halts at instruction boundaries,
// faults on illegal instructions or memory timeouts, and keeps
// cycle and retired-instruction counters.
//
// state   | meaning
// --------+----------------------------------------------------------
// FETCH   | instruction read in flight, IR loads on mem_ready
// DECODE  | one cycle for register file reads to settle
// EXECUTE | dispatch on class; branches resolve and retire here
// MEM     | data load/store in flight; stores retire on mem_ready
// WB      | register file write and PC update; instruction retires
// HALT    | parked at a boundary while halt_req is held
// FAULT   | illegal instruction or memory timeout; left only by reset
module multicycle_sequencer #(
    parameter int XLEN        = 32,
    parameter int CNT_WIDTH   = 64,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           instr_class,
    input  logic                 branch_taken,
    input  logic                 mem_ready,
    input  logic                 halt_req,
    output logic                 mem_req,
    output logic                 mem_fetch,
    output logic                 mem_we,
    output logic                 ir_load,
    output logic                 rf_we,
    output logic [1:0]           pc_sel,
    output logic [XLEN-1:0]      pc_inc,
    output logic [2:0]           state,
    output logic                 halted,
    output logic                 fault,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instret_count
);

    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

    localparam logic [2:0] C_ALU    = 3'd0;
    localparam logic [2:0] C_LOAD   = 3'd1;
    localparam logic [2:0] C_STORE  = 3'd2;
    localparam logic [2:0] C_BRANCH = 3'd3;
    localparam logic [2:0] C_JAL    = 3'd4;
    localparam logic [2:0] C_JALR   = 3'd5;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5,
        S_FAULT   = 3'd6
    } state_t;

    state_t               state_q, state_d, boundary_c;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [CNT_WIDTH-1:0] cycle_q, instret_q;
    logic                 mem_phase, timeout_c;
    logic                 we_c, ir_c, rf_c, retire_c;
    logic [1:0]           pc_sel_c;

    assign mem_phase  = (state_q == S_FETCH) || (state_q == S_MEM);
    // A stalled request faults once it has waited MEM_TIMEOUT cycles already.
    assign timeout_c  = (MEM_TIMEOUT != 0) && mem_phase && !mem_ready
                        && (wait_q == TIMEOUT_VAL);
    assign boundary_c = halt_req ? S_HALT : S_FETCH;

    // Next-state decode plus the per-state control strobes.
    always_comb begin
        state_d  = state_q;
        we_c     = 1'b0;
        ir_c     = 1'b0;
        rf_c     = 1'b0;
        retire_c = 1'b0;
        pc_sel_c = 2'd0;
        case (state_q)
            S_FETCH: begin
                if (timeout_c) begin
                    state_d = S_FAULT;
                end else if (mem_ready) begin
                    ir_c    = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                case (instr_class)
                    C_LOAD, C_STORE:     state_d = S_MEM;
                    C_ALU, C_JAL, C_JALR: state_d = S_WB;
                    C_BRANCH: begin
                        pc_sel_c = branch_taken ? 2'd2 : 2'd1;
                        retire_c = 1'b1;
                        state_d  = boundary_c;
                    end
                    default:             state_d = S_FAULT;
                endcase
            end
            S_MEM: begin
                we_c = (instr_class == C_STORE);
                if (timeout_c) begin
                    state_d = S_FAULT;
                end else if (mem_ready) begin
                    if (instr_class == C_STORE) begin
                        pc_sel_c = 2'd1;
                        retire_c = 1'b1;
                        state_d  = boundary_c;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_c     = 1'b1;
                retire_c = 1'b1;
                case (instr_class)
                    C_JAL:   pc_sel_c = 2'd2;
                    C_JALR:  pc_sel_c = 2'd3;
                    default: pc_sel_c = 2'd1;
                endcase
                state_d = boundary_c;
            end
            S_HALT: begin
                if (!halt_req) state_d = S_FETCH;
            end
            default: state_d = S_FAULT;
        endcase
    end

    // Wait counter runs only while a request is stalled in the same state.
    always_comb begin
        wait_d = '0;
        if (mem_phase && !mem_ready && (state_d == state_q)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    // State, wait counter and performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if ((state_q != S_HALT) && (state_q != S_FAULT)) begin
                cycle_q <= cycle_q + CNT_WIDTH'(1);
            end
            if (retire_c) begin
                instret_q <= instret_q + CNT_WIDTH'(1);
            end
        end
    end

    // Outputs are forced low while reset is held so an in-flight store
    // drops its request immediately, without waiting for a clock.
    assign mem_req       = rst_n & mem_phase;
    assign mem_fetch     = rst_n & (state_q == S_FETCH);
    assign mem_we        = rst_n & we_c;
    assign ir_load       = rst_n & ir_c;
    assign rf_we         = rst_n & rf_c;
    assign pc_sel        = rst_n ? pc_sel_c : 2'd0;
    assign halted        = rst_n & (state_q == S_HALT);
    assign fault         = rst_n & (state_q == S_FAULT);
    assign state         = state_q;
    assign pc_inc        = XLEN'(4);
    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: a random instruction stream
// with random memory wait states, checked per retirement against a
// latency/strobe model, followed by directed halt, timeout, illegal and
// asynchronous-reset scenarios.
module tb_multicycle_sequencer;

    localparam int N_INSTR = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  instr_class;
    logic        branch_taken;
    logic        mem_ready;
    logic        halt_req;
    logic        mem_req, mem_fetch, mem_we, ir_load, rf_we, halted, fault;
    logic [1:0]  pc_sel;
    logic [31:0] pc_inc;
    logic [2:0]  state;
    logic [63:0] cycle_count, instret_count;

    multicycle_sequencer #(
        .XLEN(32), .CNT_WIDTH(64), .MEM_TIMEOUT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .instr_class(instr_class),
        .branch_taken(branch_taken), .mem_ready(mem_ready), .halt_req(halt_req),
        .mem_req(mem_req), .mem_fetch(mem_fetch), .mem_we(mem_we),
        .ir_load(ir_load), .rf_we(rf_we), .pc_sel(pc_sel), .pc_inc(pc_inc),
        .state(state), .halted(halted), .fault(fault),
        .cycle_count(cycle_count), .instret_count(instret_count)
    );

    always #5 clk = ~clk;

    typedef struct { int cls; int bt; int fw; int mw; } stim_t;
    typedef struct { int lat; int rf; int pc; int we; } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];

    int total = 0;
    int bad   = 0;
    bit sb_on = 0;
    int sb_retired = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    // Reference model: cycle cost and visible strobes of one instruction.
    function automatic exp_t model(stim_t s);
        exp_t e;
        int fetch_cyc = s.fw + 1;
        int mem_cyc   = s.mw + 1;
        e.we = 0;
        e.rf = 0;
        case (s.cls)
            1: begin e.lat = fetch_cyc + 2 + mem_cyc + 1; e.rf = 1; e.pc = 1; end
            2: begin e.lat = fetch_cyc + 2 + mem_cyc; e.pc = 1; e.we = mem_cyc; end
            3: begin e.lat = fetch_cyc + 2; e.pc = (s.bt != 0) ? 2 : 1; end
            4: begin e.lat = fetch_cyc + 3; e.rf = 1; e.pc = 2; end
            5: begin e.lat = fetch_cyc + 3; e.rf = 1; e.pc = 3; end
            default: begin e.lat = fetch_cyc + 3; e.rf = 1; e.pc = 1; end
        endcase
        return e;
    endfunction

    // Memory responder: pops one stimulus item per fetch and answers each
    // request after its chosen number of wait cycles.
    stim_t cur;
    int    need, cnt, cur_mw;
    bit    busy;
    initial begin
        mem_ready = 1'b0; instr_class = 3'd0; branch_taken = 1'b0;
        busy = 0; need = 0; cnt = 0; cur_mw = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || !mem_req) begin
                mem_ready = 1'b0;
                busy = 0;
            end else begin
                if (!busy) begin
                    busy = 1;
                    cnt  = 0;
                    if (mem_fetch) begin
                        if (stim_q.size() > 0) cur = stim_q.pop_front();
                        else cur = '{0, 0, 0, 0};
                        instr_class  = 3'(cur.cls);
                        branch_taken = (cur.bt != 0);
                        need   = cur.fw;
                        cur_mw = cur.mw;
                    end else begin
                        need = cur_mw;
                    end
                end else begin
                    cnt++;
                end
                mem_ready = (cnt == need);
                if (mem_ready) busy = 0;
            end
        end
    end

    // Monitor: accumulates strobes per instruction, checks on each retirement.
    logic [63:0] prev_instret, prev_cycle;
    int acc_rf, acc_pc, acc_we, acc_ir;
    initial begin
        exp_t e;
        prev_instret = 0; prev_cycle = 0;
        acc_rf = 0; acc_pc = 0; acc_we = 0; acc_ir = 0;
        forever begin
            tick();
            if (sb_on && rst_n) begin
                if (instret_count != prev_instret) begin
                    check("instret_step", instret_count - prev_instret, 64'd1);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_retire: got instret %0d, expected none", instret_count);
                    end else begin
                        e = exp_q.pop_front();
                        check("latency", cycle_count - prev_cycle, 64'(e.lat));
                        check("rf_we_cycles", 64'(acc_rf), 64'(e.rf));
                        check("pc_sel", 64'(acc_pc), 64'(e.pc));
                        check("mem_we_cycles", 64'(acc_we), 64'(e.we));
                        check("ir_load_cycles", 64'(acc_ir), 64'd1);
                    end
                    prev_instret = instret_count;
                    prev_cycle   = cycle_count;
                    acc_rf = 0; acc_pc = 0; acc_we = 0; acc_ir = 0;
                    sb_retired++;
                end
                acc_rf += int'(rf_we);
                acc_we += int'(mem_we);
                acc_ir += int'(ir_load);
                if (pc_sel != 2'd0) acc_pc = int'(pc_sel);
            end
        end
    end

    task automatic restart(stim_t s);
        rst_n = 1'b0;
        sb_on = 0;
        halt_req = 1'b0;
        stim_q.delete();
        repeat (2) @(posedge clk);
        stim_q.push_back(s);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        stim_t s;
        bit    seen;
        logic [63:0] frozen;
        rst_n = 1'b0;
        halt_req = 1'b0;
        #3;
        check("rst_state", 64'(state), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_fetch", 64'(mem_fetch), 64'd0);
        check("rst_cycle", cycle_count, 64'd0);
        check("rst_instret", instret_count, 64'd0);
        check("rst_pc_inc", 64'(pc_inc), 64'd4);

        // Random stream; wait states up to 4 sit exactly on the timeout limit.
        for (int i = 0; i < N_INSTR; i++) begin
            s.cls = int'($urandom_range(0, 5));
            s.bt  = int'($urandom_range(0, 1));
            s.fw  = int'($urandom_range(0, 4));
            s.mw  = int'($urandom_range(0, 4));
            stim_q.push_back(s);
            exp_q.push_back(model(s));
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb_on = 1;
        for (int c = 0; c < 2000 && sb_retired < N_INSTR; c++) tick();
        sb_on = 0;
        check("random_retired", 64'(sb_retired), 64'(N_INSTR));
        check("random_no_fault", 64'(fault), 64'd0);

        // Halt requested in DECODE of an ALU instruction.
        restart('{0, 0, 0, 0});
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (state == 3'd1) seen = 1;
        end
        check("halt_saw_decode", 64'(seen), 64'd1);
        halt_req = 1'b1;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (halted) seen = 1;
        end
        check("halt_reached", 64'(seen), 64'd1);
        check("halt_state", 64'(state), 64'd5);
        check("halt_cycle", cycle_count, 64'd4);
        check("halt_instret", instret_count, 64'd1);
        repeat (3) tick();
        check("halt_frozen", cycle_count, 64'd4);
        check("halt_held", 64'(halted), 64'd1);
        halt_req = 1'b0;
        tick();
        check("resume_fetch", 64'(state), 64'd0);
        check("resume_halted", 64'(halted), 64'd0);

        // Fetch never answered: fault after the fifth request cycle.
        restart('{0, 0, 100, 0});
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("to_req_%0d", i), 64'(mem_req), 64'd1);
            check($sformatf("to_nofault_%0d", i), 64'(fault), 64'd0);
        end
        tick();
        check("to_fault", 64'(fault), 64'd1);
        check("to_state", 64'(state), 64'd6);
        check("to_mem_req", 64'(mem_req), 64'd0);
        check("to_cycle", cycle_count, 64'd5);
        frozen = cycle_count;
        halt_req = 1'b1;
        repeat (3) tick();
        check("to_sticky", 64'(state), 64'd6);
        check("to_frozen", cycle_count, frozen);
        halt_req = 1'b0;

        // Illegal class goes to FAULT out of EXECUTE.
        restart('{6, 0, 0, 0});
        tick(); check("ill_fetch", 64'(state), 64'd0);
        tick(); check("ill_decode", 64'(state), 64'd1);
        tick(); check("ill_execute", 64'(state), 64'd2);
        tick(); check("ill_fault", 64'(state), 64'd6);
        check("ill_fault_flag", 64'(fault), 64'd1);
        check("ill_instret", instret_count, 64'd0);

        // Asynchronous reset while a store is in MEM.
        restart('{2, 0, 0, 3});
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (state == 3'd3) seen = 1;
        end
        check("st_saw_mem", 64'(seen), 64'd1);
        check("st_mem_we", 64'(mem_we), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("ar_mem_we", 64'(mem_we), 64'd0);
        check("ar_mem_req", 64'(mem_req), 64'd0);
        check("ar_state", 64'(state), 64'd0);
        check("ar_cycle", cycle_count, 64'd0);
        check("ar_instret", instret_count, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
